// File: rtl/risc_core.sv
// risc_core: five-stage PC/IF/ID/EX/MEM/WB integer pipeline with ROM, register file and ALU
module risc_core #(
  parameter int RFW = 5,
  parameter int IMW = 4,
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter logic [(2**IMW)*IW-1:0] IMEM_INIT = {
    {8{32'h0000_0000}},
    32'h0041_282A, 32'h0022_2022, 32'h0022_1820,
    {3{32'h0000_0000}},
    32'h2002_0003, 32'h2001_0005
  }
) (
  input  logic           clk,
  input  logic           rf_reset,
  input  logic [IMW-1:0] pc_in,
  input  logic           im_cs,
  input  logic           rf_we_e,
  output logic [IMW-1:0] pc_out,
  output logic [IW-1:0]  if_id_out,
  output logic [DW-1:0]  id_exe_r1,
  output logic [DW-1:0]  id_exe_r2,
  output logic [DW-1:0]  exe_mem_out,
  output logic [DW-1:0]  mem_wb_out
);
  typedef enum logic [2:0] {A_NOP, A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_PASS} alu_e;
  logic [IW-1:0]  imem [2**IMW];
  logic [DW-1:0]  rf_q [2**RFW];
  logic [IMW-1:0] pc_q;
  logic [IW-1:0]  ifid_q;
  logic [DW-1:0]  r1_q, r2_q, imm_q, em_q, mw_q;
  logic [RFW-1:0] idd_q, emd_q, mwd_q;
  logic           idv_q, emv_q, mwv_q, bsel_q;
  alu_e           alu_q, alu_d;
  logic [DW-1:0]  imm_d, res_d, rs_val, rt_val, b_val;
  logic [RFW-1:0] dst_d, rs, rt, rd;
  logic [5:0]     op, funct;
  logic [15:0]    imm;
  logic           bsel_d, vld_d, wb_we;
  logic           unused_shamt;
  for (genvar i = 0; i < 2**IMW; i++) begin : g_rom
    assign imem[i] = IMEM_INIT[i*IW +: IW];
  end
  assign op           = ifid_q[31:26];
  assign rs           = ifid_q[25:21];
  assign rt           = ifid_q[20:16];
  assign rd           = ifid_q[15:11];
  assign funct        = ifid_q[5:0];
  assign imm          = ifid_q[15:0];
  assign unused_shamt = ^ifid_q[10:6];
  // A retiring WB write is visible to the ID read of the same register in the same cycle
  assign wb_we  = rf_we_e & mwv_q & (mwd_q != '0);
  assign rs_val = (wb_we && mwd_q == rs) ? mw_q : rf_q[rs];
  assign rt_val = (wb_we && mwd_q == rt) ? mw_q : rf_q[rt];
  // Decode: map op/funct to an ALU operation, select immediate form and destination
  always_comb begin
    alu_d  = (op == 6'h00) ? (funct == 6'h20 ? A_ADD : funct == 6'h22 ? A_SUB :
                              funct == 6'h24 ? A_AND : funct == 6'h25 ? A_OR  :
                              funct == 6'h26 ? A_XOR : funct == 6'h2A ? A_SLT : A_NOP) :
             op == 6'h08 ? A_ADD : op == 6'h0C ? A_AND : op == 6'h0D ? A_OR :
             op == 6'h0F ? A_PASS : A_NOP;
    bsel_d = op != 6'h00;
    imm_d  = op == 6'h08 ? {{(DW-16){imm[15]}}, imm} :
             op == 6'h0F ? {imm, {(DW-16){1'b0}}} : {{(DW-16){1'b0}}, imm};
    dst_d  = op == 6'h00 ? rd : rt;
    vld_d  = alu_d != A_NOP;
  end
  // Execute: unknown operations produce zero
  always_comb begin
    b_val = bsel_q ? imm_q : r2_q;
    res_d = alu_q == A_ADD  ? r1_q + b_val :
            alu_q == A_SUB  ? r1_q - b_val :
            alu_q == A_AND  ? r1_q & b_val :
            alu_q == A_OR   ? r1_q | b_val :
            alu_q == A_XOR  ? r1_q ^ b_val :
            alu_q == A_SLT  ? DW'($signed(r1_q) < $signed(b_val)) :
            alu_q == A_PASS ? b_val : '0;
  end
  // Pipeline registers advance every edge; reset flushes everything in flight
  always_ff @(posedge clk or negedge rf_reset) begin
    if (!rf_reset) begin
      pc_q   <= '0;
      ifid_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      imm_q  <= '0;
      alu_q  <= A_NOP;
      bsel_q <= 1'b0;
      idd_q  <= '0;
      idv_q  <= 1'b0;
      em_q   <= '0;
      emd_q  <= '0;
      emv_q  <= 1'b0;
      mw_q   <= '0;
      mwd_q  <= '0;
      mwv_q  <= 1'b0;
    end else begin
      pc_q   <= pc_in;
      ifid_q <= im_cs ? imem[pc_q] : '0;
      r1_q   <= rs_val;
      r2_q   <= rt_val;
      imm_q  <= imm_d;
      alu_q  <= alu_d;
      bsel_q <= bsel_d;
      idd_q  <= dst_d;
      idv_q  <= vld_d;
      em_q   <= res_d;
      emd_q  <= idd_q;
      emv_q  <= idv_q;
      mw_q   <= em_q;
      mwd_q  <= emd_q;
      mwv_q  <= emv_q;
    end
  end
  // Register file write port; r0 is never written so it reads as zero
  always_ff @(posedge clk or negedge rf_reset) begin
    if (!rf_reset) begin
      for (int j = 0; j < 2**RFW; j++) rf_q[j] <= '0;
    end else if (wb_we) begin
      rf_q[mwd_q] <= mw_q;
    end
  end
  assign pc_out      = pc_q;
  assign if_id_out   = ifid_q;
  assign id_exe_r1   = r1_q;
  assign id_exe_r2   = r2_q;
  assign exe_mem_out = em_q;
  assign mem_wb_out  = mw_q;
endmodule

// File: tb/tb_risc_core.sv
// tb_risc_core: directed checks of fetch, pipeline timing, program results, write disable and reset
module tb_risc_core;
  logic clk = 1'b0, rf_reset = 1'b1, im_cs = 1'b0, rf_we_e = 1'b0, sel = 1'b0;
  logic [3:0]  pc_in = '0;
  logic [3:0]  d_pc, w_pc, pc;
  logic [31:0] d_ifid, d_r1, d_r2, d_em, d_mw, w_ifid, w_r1, w_r2, w_em, w_mw;
  logic [31:0] ifid, r1, r2, em, mw;
  logic [31:0] em_exp [16];
  logic [31:0] rf_exp [32];
  logic [31:0] ide_r1, ide_r2;
  int ide_n;
  int checks = 0, errors = 0;
  localparam logic [511:0] WRAP_PROG = {
    {4{32'h0000_0000}},
    32'hFC0E_0000, 32'h0128_6825, 32'h0027_6024, 32'h0020_582A,
    32'h3409_8001, 32'h0026_5026, 32'h3028_80F0, 32'h3C07_1234,
    32'h0021_3020, 32'h0000_0000, 32'h2000_0007, 32'h2001_FFFF
  };
  risc_core u_dut (.clk(clk), .rf_reset(rf_reset), .pc_in(pc_in), .im_cs(im_cs), .rf_we_e(rf_we_e),
                   .pc_out(d_pc), .if_id_out(d_ifid), .id_exe_r1(d_r1), .id_exe_r2(d_r2),
                   .exe_mem_out(d_em), .mem_wb_out(d_mw));
  risc_core #(.IMEM_INIT(WRAP_PROG)) u_wrap (.clk(clk), .rf_reset(rf_reset), .pc_in(pc_in), .im_cs(im_cs),
                   .rf_we_e(rf_we_e), .pc_out(w_pc), .if_id_out(w_ifid), .id_exe_r1(w_r1),
                   .id_exe_r2(w_r2), .exe_mem_out(w_em), .mem_wb_out(w_mw));
  assign pc   = sel ? w_pc   : d_pc;
  assign ifid = sel ? w_ifid : d_ifid;
  assign r1   = sel ? w_r1   : d_r1;
  assign r2   = sel ? w_r2   : d_r2;
  assign em   = sel ? w_em   : d_em;
  assign mw   = sel ? w_mw   : d_mw;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rf_rd(input int i);
    return sel ? u_wrap.rf_q[i] : u_dut.rf_q[i];
  endfunction
  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_rf%0d", tag, i), rf_rd(i), rf_exp[i]);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_ifid"}, ifid, 32'h0);
    chk({tag, "_r1"}, r1, 32'h0);
    chk({tag, "_r2"}, r2, 32'h0);
    chk({tag, "_em"}, em, 32'h0);
    chk({tag, "_mw"}, mw, 32'h0);
  endtask
  task automatic do_reset();
    rf_reset = 1'b0;
    #1;
    rf_reset = 1'b1;
  endtask
  task automatic run_prog(input string tag, input logic we);
    rf_we_e = we;
    im_cs   = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      pc_in = (n - 1 > 15) ? 4'd15 : 4'(n - 1);
      step();
      chk($sformatf("%s_pc%0d", tag, n), 32'(pc), 32'(pc_in));
      if (n >= 4 && n <= 19) chk($sformatf("%s_em%0d", tag, n - 4), em, em_exp[n-4]);
      if (n >= 5 && n <= 20) chk($sformatf("%s_mw%0d", tag, n - 5), mw, em_exp[n-5]);
      if (n == ide_n) begin
        chk({tag, "_idr1"}, r1, ide_r1);
        chk({tag, "_idr2"}, r2, ide_r2);
      end
    end
    check_rf(tag);
  endtask
  initial begin
    #1 rf_reset = 1'b0;
    #1;
    check_zero("rst");
    rf_exp = '{default: 32'h0};
    check_rf("rst");
    #1 rf_reset = 1'b1;
    im_cs = 1'b1;
    pc_in = 4'd0;
    step();
    chk("fetch_pc0", 32'(pc), 32'h0);
    pc_in = 4'd1;
    step();
    chk("fetch_pc1", 32'(pc), 32'h1);
    chk("fetch_i0", ifid, 32'h2001_0005);
    step();
    chk("fetch_i1", ifid, 32'h2002_0003);
    im_cs = 1'b0;
    step();
    chk("fetch_cs0", ifid, 32'h0);
    do_reset();
    em_exp = '{32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd8, 32'd2, 32'd1,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    rf_exp = '{default: 32'h0};
    rf_exp[1] = 32'd5; rf_exp[2] = 32'd3; rf_exp[3] = 32'd8; rf_exp[4] = 32'd2; rf_exp[5] = 32'd1;
    ide_n = 8; ide_r1 = 32'd5; ide_r2 = 32'd3;
    run_prog("prog", 1'b1);
    #2 rf_reset = 1'b0;
    #1;
    check_zero("arst");
    rf_exp = '{default: 32'h0};
    check_rf("arst");
    rf_reset = 1'b1;
    step();
    em_exp = '{32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    ide_r1 = 32'd0; ide_r2 = 32'd0;
    run_prog("nowe", 1'b0);
    do_reset();
    sel = 1'b1;
    em_exp = '{32'hFFFF_FFFF, 32'h7, 32'h0, 32'hFFFF_FFFE, 32'h1234_0000, 32'h80F0, 32'h1, 32'h8001,
               32'h1, 32'h1234_0000, 32'h80F1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rf_exp = '{default: 32'h0};
    rf_exp[1] = 32'hFFFF_FFFF; rf_exp[6] = 32'hFFFF_FFFE; rf_exp[7] = 32'h1234_0000;
    rf_exp[8] = 32'h80F0; rf_exp[9] = 32'h8001; rf_exp[10] = 32'h1; rf_exp[11] = 32'h1;
    rf_exp[12] = 32'h1234_0000; rf_exp[13] = 32'h80F1;
    ide_n = 6; ide_r1 = 32'hFFFF_FFFF; ide_r2 = 32'hFFFF_FFFF;
    run_prog("wrap", 1'b1);
    sel = 1'b0;
    do_reset();
    rf_we_e = 1'b1;
    im_cs   = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      pc_in = 4'(n - 1);
      step();
    end
    chk("flight_mw", mw, 32'd5);
    #2 rf_reset = 1'b0;
    #1;
    check_zero("flight");
    rf_reset = 1'b1;
    im_cs = 1'b0;
    pc_in = 4'd2;
    for (int n = 0; n < 8; n++) step();
    rf_exp = '{default: 32'h0};
    check_rf("flight");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
